// File: rtl/time_pkg.sv
// Shared types and constants for the digital-clock time-unit stages.
package time_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam int SEC_MODULUS   = 60;
  localparam int MIN_MODULUS   = 60;
  localparam int HOUR_MODULUS  = 24;
  localparam int DEFAULT_WIDTH = 6;

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational binary (0..99) to two BCD digits; also used by the display path.
module bin2bcd_2digit (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Constant divisors map to small LUT trees; inputs above 99 are never presented.
  assign tens = 4'(bin / 7'd10);
  assign ones = 4'(bin % 7'd10);

endmodule

// File: rtl/time_unit_counter.sv
// Cascadable modulo-MODULUS up/down time-unit stage with preset, SET-mode
// adjustment and BCD outputs.
module time_unit_counter
  import time_pkg::*;
#(
  parameter int MODULUS = SEC_MODULUS,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             dir,
  input  logic             hold,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             set_mode,
  input  logic             adj_up,
  input  logic             adj_dn,
  output logic [WIDTH-1:0] count,
  output logic             tick_out,
  output logic             load_err,
  output logic             in_set,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("time_unit_counter: MODULUS must be within 2..100");
  end
  if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
    $error("time_unit_counter: WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             tick_reg, tick_next;
  logic             err_reg, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      count_reg <= '0;
      tick_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      tick_reg  <= tick_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = set_mode ? ST_SET : ST_RUN;
    count_next = count_reg;
    tick_next  = 1'b0;
    err_next   = err_reg;

    if (load_en) begin
      // A preset swallows any tick or adjust pulse arriving in the same cycle.
      if (32'(load_val) < MODULUS) begin
        count_next = load_val;
        err_next   = 1'b0;
      end else begin
        err_next   = 1'b1;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (tick_in && !hold) begin
            if (!dir) begin
              if (count_reg == MAX_VAL) begin
                count_next = ZERO;
                tick_next  = 1'b1;
              end else begin
                count_next = count_reg + ONE;
              end
            end else begin
              if (count_reg == ZERO) begin
                count_next = MAX_VAL;
                tick_next  = 1'b1;
              end else begin
                count_next = count_reg - ONE;
              end
            end
          end
        end
        ST_SET: begin
          // Manual adjustment wraps silently: the next stage must not move.
          if (adj_up && !adj_dn) begin
            count_next = (count_reg == MAX_VAL) ? ZERO : count_reg + ONE;
          end else if (adj_dn && !adj_up) begin
            count_next = (count_reg == ZERO) ? MAX_VAL : count_reg - ONE;
          end
        end
        default: begin
          count_next = count_reg;
        end
      endcase
    end
  end

  assign count    = count_reg;
  assign tick_out = tick_reg;
  assign load_err = err_reg;
  assign in_set   = (state_reg == ST_SET);

  logic [6:0] count7;
  if (WIDTH >= 7) begin : g_trunc
    assign count7 = count_reg[6:0];
  end else begin : g_ext
    assign count7 = {{(7 - WIDTH){1'b0}}, count_reg};
  end

  bin2bcd_2digit u_bcd (
    .bin  (count7),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench: table-driven vectors on a mod-60 stage, plus hand sequences
// for wrap, borrow (mod-24), hold and a two-stage cascade.
module tb_time_unit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // ---------------- mod-60 stage ----------------
  logic       rst, tick_in, dir, hold, load_en, set_mode, adj_up, adj_dn;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       tick_out, load_err, in_set;
  logic [3:0] bcd_tens, bcd_ones;

  time_unit_counter #(.MODULUS(60), .WIDTH(6)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .dir(dir), .hold(hold),
    .load_en(load_en), .load_val(load_val), .set_mode(set_mode),
    .adj_up(adj_up), .adj_dn(adj_dn), .count(count), .tick_out(tick_out),
    .load_err(load_err), .in_set(in_set), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
  );

  // ---------------- mod-24 stage ----------------
  logic       h_rst, h_tick, h_dir, h_load_en;
  logic [4:0] h_load_val, h_count;
  logic       h_tick_out, h_load_err, h_in_set;
  logic [3:0] h_tens, h_ones;

  time_unit_counter #(.MODULUS(24), .WIDTH(5)) dut24 (
    .clk(clk), .rst(h_rst), .tick_in(h_tick), .dir(h_dir), .hold(1'b0),
    .load_en(h_load_en), .load_val(h_load_val), .set_mode(1'b0),
    .adj_up(1'b0), .adj_dn(1'b0), .count(h_count), .tick_out(h_tick_out),
    .load_err(h_load_err), .in_set(h_in_set), .bcd_tens(h_tens), .bcd_ones(h_ones)
  );

  // ---------------- cascade 60 -> 60 ----------------
  logic       c_rst, c_tick;
  logic [5:0] lo_count, hi_count;
  logic       lo_tick_out, hi_tick_out, lo_err, hi_err, lo_set, hi_set;
  logic [3:0] lo_tens, lo_ones, hi_tens, hi_ones;

  time_unit_counter #(.MODULUS(60), .WIDTH(6)) u_lo (
    .clk(clk), .rst(c_rst), .tick_in(c_tick), .dir(1'b0), .hold(1'b0),
    .load_en(1'b0), .load_val(6'd0), .set_mode(1'b0), .adj_up(1'b0), .adj_dn(1'b0),
    .count(lo_count), .tick_out(lo_tick_out), .load_err(lo_err), .in_set(lo_set),
    .bcd_tens(lo_tens), .bcd_ones(lo_ones)
  );

  time_unit_counter #(.MODULUS(60), .WIDTH(6)) u_hi (
    .clk(clk), .rst(c_rst), .tick_in(lo_tick_out), .dir(1'b0), .hold(1'b0),
    .load_en(1'b0), .load_val(6'd0), .set_mode(1'b0), .adj_up(1'b0), .adj_dn(1'b0),
    .count(hi_count), .tick_out(hi_tick_out), .load_err(hi_err), .in_set(hi_set),
    .bcd_tens(hi_tens), .bcd_ones(hi_ones)
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle60();
    rst = 0; tick_in = 0; dir = 0; hold = 0; load_en = 0; load_val = 0;
    set_mode = 0; adj_up = 0; adj_dn = 0;
  endtask

  typedef struct {
    logic       rst, tick, dir, hold, ld;
    logic [5:0] lv;
    logic       sm, au, ad;
    logic [5:0] e_count;
    logic       e_tick, e_err, e_set;
    logic [3:0] e_tens, e_ones;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  initial begin
    //          rst tk dr hd ld lv  sm au ad   cnt tk er st  T  O
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 45, 0, 0, 0,   45, 0, 0, 0, 4, 5};
    vecs[2]  = '{0, 0, 0, 0, 1, 63, 0, 0, 0,   45, 0, 1, 0, 4, 5};
    vecs[3]  = '{0, 1, 0, 0, 1, 10, 0, 0, 0,   10, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0,   11, 0, 0, 0, 1, 1};
    vecs[5]  = '{0, 1, 1, 0, 0,  0, 0, 0, 0,   10, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 1, 0,  0, 0, 0, 0,   10, 0, 0, 0, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, 59, 0, 0, 0,   59, 0, 0, 0, 5, 9};
    vecs[8]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0,    0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 1, 0, 0,  0, 0, 0, 0,   59, 1, 0, 0, 5, 9};
    vecs[11] = '{0, 1, 1, 0, 0,  0, 1, 0, 0,   58, 0, 0, 1, 5, 8};
    vecs[12] = '{0, 0, 0, 0, 1, 59, 1, 0, 0,   59, 0, 0, 1, 5, 9};
    vecs[13] = '{0, 0, 0, 0, 0,  0, 1, 1, 0,    0, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0,  0, 1, 0, 1,   59, 0, 0, 1, 5, 9};
    vecs[15] = '{0, 0, 0, 0, 0,  0, 1, 1, 1,   59, 0, 0, 1, 5, 9};
    vecs[16] = '{0, 1, 0, 0, 0,  0, 1, 0, 0,   59, 0, 0, 1, 5, 9};
    vecs[17] = '{0, 0, 0, 0, 0,  0, 1, 0, 1,   58, 0, 0, 1, 5, 8};
    vecs[18] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,   58, 0, 0, 0, 5, 8};
    vecs[19] = '{0, 1, 0, 0, 0,  0, 0, 0, 0,   59, 0, 0, 0, 5, 9};
    vecs[20] = '{0, 0, 0, 0, 1, 37, 1, 0, 0,   37, 0, 0, 1, 3, 7};
    vecs[21] = '{0, 0, 0, 0, 1, 60, 1, 0, 0,   37, 0, 1, 1, 3, 7};
    vecs[22] = '{1, 1, 0, 0, 1,  5, 1, 1, 0,    0, 0, 0, 0, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0};

    idle60();
    h_rst = 1; h_tick = 0; h_dir = 0; h_load_en = 0; h_load_val = 0;
    c_rst = 1; c_tick = 0;
    @(negedge clk);

    // ---- table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; tick_in = vecs[i].tick; dir = vecs[i].dir;
      hold = vecs[i].hold; load_en = vecs[i].ld; load_val = vecs[i].lv;
      set_mode = vecs[i].sm; adj_up = vecs[i].au; adj_dn = vecs[i].ad;
      step();
      check($sformatf("vec%0d count", i), int'(count), int'(vecs[i].e_count));
      check($sformatf("vec%0d tick_out", i), int'(tick_out), int'(vecs[i].e_tick));
      check($sformatf("vec%0d load_err", i), int'(load_err), int'(vecs[i].e_err));
      check($sformatf("vec%0d in_set", i), int'(in_set), int'(vecs[i].e_set));
      check($sformatf("vec%0d bcd_tens", i), int'(bcd_tens), int'(vecs[i].e_tens));
      check($sformatf("vec%0d bcd_ones", i), int'(bcd_ones), int'(vecs[i].e_ones));
      $display("vector %0d: count=%0d tick_out=%0d load_err=%0d in_set=%0d", i,
               count, tick_out, load_err, in_set);
    end

    // ---- hold: five ticks lost, not queued ----
    idle60(); load_en = 1; load_val = 6'd20; step();
    idle60(); hold = 1; tick_in = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold count", int'(count), 20);
      check("hold tick_out", int'(tick_out), 0);
    end
    idle60(); step();
    check("after hold count", int'(count), 20);
    tick_in = 1; step();
    check("post hold tick count", int'(count), 21);
    $display("hold sequence: count=%0d", count);

    // ---- up wrap over full mod-60 range ----
    idle60(); rst = 1; step();
    idle60(); tick_in = 1;
    for (int k = 1; k <= 60; k++) begin
      step();
      check($sformatf("wrap count k=%0d", k), int'(count), k % 60);
      check($sformatf("wrap tick_out k=%0d", k), int'(tick_out), (k == 60) ? 1 : 0);
      if (k == 59) begin
        check("wrap bcd_tens@59", int'(bcd_tens), 5);
        check("wrap bcd_ones@59", int'(bcd_ones), 9);
      end
    end
    idle60(); step();
    check("wrap tick_out drop", int'(tick_out), 0);
    $display("up wrap sequence: count=%0d", count);

    // ---- down borrow on mod-24 stage ----
    h_rst = 0; h_load_en = 1; h_load_val = 5'd0; step();
    check("h preset count", int'(h_count), 0);
    h_load_en = 0; h_tick = 1; h_dir = 1; step();
    check("h borrow count", int'(h_count), 23);
    check("h borrow tick_out", int'(h_tick_out), 1);
    check("h bcd_tens@23", int'(h_tens), 2);
    check("h bcd_ones@23", int'(h_ones), 3);
    step();
    check("h second count", int'(h_count), 22);
    check("h second tick_out", int'(h_tick_out), 0);
    h_tick = 0; h_load_en = 1; h_load_val = 5'd24; step();
    check("h load 24 err", int'(h_load_err), 1);
    check("h load 24 count", int'(h_count), 22);
    h_load_en = 0;
    $display("down borrow sequence: count=%0d", h_count);

    // ---- cascade: 3600 ticks into the lower stage ----
    begin
      int lo_pulses = 0;
      int hi_pulses = 0;
      c_rst = 0; c_tick = 1;
      for (int k = 1; k <= 3602; k++) begin
        if (k == 3601) c_tick = 0;
        step();
        if (lo_tick_out) lo_pulses++;
        if (hi_tick_out) hi_pulses++;
        if (k == 3600) begin
          check("cascade lo@3600", int'(lo_count), 0);
          check("cascade hi@3600", int'(hi_count), 59);
        end
      end
      check("cascade lo pulses", lo_pulses, 60);
      check("cascade hi pulses", hi_pulses, 1);
      check("cascade hi final", int'(hi_count), 0);
      check("cascade lo final", int'(lo_count), 0);
      $display("cascade sequence: lo_pulses=%0d hi_pulses=%0d", lo_pulses, hi_pulses);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
